imem_loader: RTL

Instruction-memory responder for the pipelined core's fetch port. It answers `instrAddrF` with `instrF` in the same cycle. After reset it first accepts a program image over a valid/ready word stream, holding the core in reset until the image is complete. It sits between the top level and the datapath's fetch stage, replacing a preinitialised ROM.

---
 rtl/imem_loader.sv | 105 ++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction-memory responder for the fetch port. After reset it loads a program
// image over a valid/ready stream and holds the core in reset until the image is complete.
module imem_loader #(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          instrAddrF,
    output logic [15:0]          instrF,
    input  logic                 load_valid,
    input  logic [15:0]          load_data,
    input  logic                 load_last,
    output logic                 load_ready,
    output logic                 cpu_reset,
    output logic                 load_done,
    output logic [ADDR_BITS:0]   load_count,
    output logic                 overflow_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam int unsigned CNT_W = ADDR_BITS + 1;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 stateNext;
    logic [CNT_W-1:0]       countQ;
    logic [CNT_W-1:0]       countNext;
    logic                   ovfQ;
    logic                   ovfNext;
    logic                   wrEn;
    logic [ADDR_BITS-1:0]   wrPtr;
    logic                   inRange;
    logic [15:0]            mem [DEPTH];

    // The word count doubles as the write pointer; it never exceeds DEPTH-1 while in LOAD.
    assign wrPtr = countQ[ADDR_BITS-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= LOAD;
            countQ <= '0;
            ovfQ   <= 1'b0;
        end else begin
            state  <= stateNext;
            countQ <= countNext;
            ovfQ   <= ovfNext;
        end
    end

    // Array deliberately has no reset; the count gate hides stale contents.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtr] <= load_data;
        end
    end

    always_comb begin
        stateNext  = state;
        countNext  = countQ;
        ovfNext    = ovfQ;
        wrEn       = 1'b0;
        load_ready = 1'b0;
        cpu_reset  = 1'b1;
        load_done  = 1'b0;
        case (state)
            LOAD: begin
                load_ready = !reset;
                if (load_valid && !reset) begin
                    wrEn      = 1'b1;
                    countNext = countQ + CNT_W'(1);
                    if (load_last) begin
                        stateNext = HOLD;
                    end else if (wrPtr == {ADDR_BITS{1'b1}}) begin
                        ovfNext   = 1'b1;
                        stateNext = HOLD;
                    end
                end
            end
            // One extra reset cycle so the core's pipeline clears after the final write.
            HOLD: begin
                stateNext = RUN;
            end
            RUN: begin
                cpu_reset = reset;
                load_done = !reset;
            end
            default: begin
                stateNext = LOAD;
            end
        endcase
    end

    assign load_count   = reset ? '0 : countQ;
    assign overflow_err = reset ? 1'b0 : ovfQ;

    // Zero-latency fetch; anything outside the loaded image reads as NOP.
    assign inRange = (instrAddrF < 16'(countQ));
    assign instrF  = (state == RUN && !reset && inRange) ? mem[instrAddrF[ADDR_BITS-1:0]] : 16'h0000;

endmodule
